// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit byte path between NUM_REQ requesters. A new
//   winner is picked for every byte by round robin. An optional per-requester
//   frame lock keeps the bytes of a multi-byte message contiguous. The winner's
//   byte is latched, and the transmitter receives a one-cycle start. The
//   arbiter then waits for tx_done. A watchdog flags a transmitter that never
//   finishes.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   req          per-requester byte request (level, held until gnt)
//   lock         requester keeps ownership for its next byte while high
//   req_data     byte of requester i on [8i+7:8i]
//   gnt          one-hot single-cycle pulse: byte of requester i accepted
//   tx_data      byte to the transmitter, stable from tx_start until tx_done
//   tx_start     single-cycle pulse: the transmitter loads tx_data
//   tx_busy      the transmitter is shifting a frame
//   tx_done      single-cycle pulse: the frame, including stop bits, is sent
//   owner        index of the current or last granted requester
//   timeout_err  sticky: the transmitter did not finish within TIMEOUT_CYC
//
// state     | meaning
// IDLE      | waiting for transmitter free and a request
// ISSUE     | gnt/tx_start pulse cycle, watchdog cleared
// WAIT_DONE | waiting for tx_done, watchdog running
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CW          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [2:0]           owner,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t        state;
  logic [2:0]    rr_ptr;
  logic          locked_hold;
  logic [CW-1:0] cnt;

  logic          own_req;
  logic [7:0]    own_data;
  logic          own_lock;
  logic          win_found;
  logic          win_by_lock;
  logic [2:0]    win_idx;
  logic [7:0]    win_data;
  logic          win_lock;
  logic [2:0]    rr_next;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    own_req  = 1'b0;
    own_data = 8'h00;
    own_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == 3'(i)) begin
        own_req  = req[i];
        own_data = req_data[8*i +: 8];
        own_lock = lock[i];
      end
    end

    win_found   = 1'b0;
    win_by_lock = 1'b0;
    win_idx     = 3'd0;
    win_data    = 8'h00;
    win_lock    = 1'b0;
    if (locked_hold && own_req) begin
      win_found   = 1'b1;
      win_by_lock = 1'b1;
      win_idx     = owner;
      win_data    = own_data;
      win_lock    = own_lock;
    end else begin
      // Two passes give "first set bit at or after rr_ptr, wrapping" without modulo arithmetic.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && (3'(i) >= rr_ptr) && req[i]) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
          win_data  = req_data[8*i +: 8];
          win_lock  = lock[i];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && (3'(i) < rr_ptr) && req[i]) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
          win_data  = req_data[8*i +: 8];
          win_lock  = lock[i];
        end
      end
    end
  end

  assign rr_next = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gnt         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      owner       <= 3'd0;
      rr_ptr      <= 3'd0;
      locked_hold <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      gnt      <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_busy && win_found) begin
            gnt         <= NUM_REQ'(1) << win_idx;
            tx_start    <= 1'b1;
            tx_data     <= win_data;
            owner       <= win_idx;
            locked_hold <= win_lock;
            if (!win_by_lock) rr_ptr <= rr_next;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt <= cnt_inc;
          // tx_done is checked first so that it wins over a coincident timeout.
          if (tx_done) begin
            timeout_err <= 1'b0;
            state       <= IDLE;
          end else if (cnt_inc == CW'(TIMEOUT_CYC)) begin
            timeout_err <= 1'b1;
            locked_hold <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  lock = 3'b000;
  logic [23:0] req_data = 24'h0;
  logic [2:0]  gnt;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic [2:0]  owner;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(20), .CW(16)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .req_data(req_data),
    .gnt(gnt), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .tx_done(tx_done), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int idx, input logic [7:0] b);
    req_data[8*idx +: 8] = b;
  endtask

  // Waits (bounded) for tx_start, then checks grant, owner and data.
  task automatic expect_start(input string tag, input int idx, input logic [7:0] data,
                              output int waited);
    logic       found;
    logic [2:0] exp_g;
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      waited++;
      if (tx_start === 1'b1) found = 1'b1;
    end
    exp_g      = 3'b000;
    exp_g[idx] = 1'b1;
    chk({tag, "_start"}, 32'(found), 32'd1);
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
    chk({tag, "_data"}, 32'(tx_data), 32'(data));
    chk({tag, "_owner"}, 32'(owner), 32'(idx));
  endtask

  // Transmitter behaviour: busy for a frame, then one tx_done pulse.
  task automatic finish(input string tag, input int delay, input logic [7:0] data);
    tx_busy = 1'b1;
    repeat (delay - 1) tick();
    chk({tag, "_hold"}, 32'(tx_data), 32'(data));
    chk({tag, "_gnt0"}, 32'(gnt), 32'd0);
    tx_done = 1'b1;
    tx_busy = 1'b0;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    int w;

    // T1: reset with every request pending
    req = 3'b111;
    set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'h33);
    repeat (3) tick();
    chk("t1_gnt", 32'(gnt), 32'd0);
    chk("t1_start", 32'(tx_start), 32'd0);
    chk("t1_data", 32'(tx_data), 32'h00);
    chk("t1_err", 32'(timeout_err), 32'd0);
    rst = 1'b1;

    // T2: round robin 0,1,2,0
    expect_start("t2a", 0, 8'h11, w);
    finish("t2a", 10, 8'h11);
    expect_start("t2b", 1, 8'h22, w);
    finish("t2b", 10, 8'h22);
    expect_start("t2c", 2, 8'h33, w);
    finish("t2c", 10, 8'h33);
    expect_start("t2d", 0, 8'h11, w);
    req = 3'b000;
    finish("t2d", 10, 8'h11);

    // T3: locked owner 0 sends A1..A3 while requester 1 waits
    req = 3'b001; lock = 3'b001; set_byte(0, 8'hA1);
    expect_start("t3a1", 0, 8'hA1, w);
    req = 3'b011; set_byte(0, 8'hA2); set_byte(1, 8'hB1);
    finish("t3a1", 6, 8'hA1);
    expect_start("t3a2", 0, 8'hA2, w);
    chk("t3_regrant_lat", 32'(w), 32'd1);
    set_byte(0, 8'hA3);
    finish("t3a2", 6, 8'hA2);
    expect_start("t3a3", 0, 8'hA3, w);
    req = 3'b010; lock = 3'b000;
    finish("t3a3", 6, 8'hA3);
    expect_start("t3b1", 1, 8'hB1, w);
    req = 3'b000;
    finish("t3b1", 6, 8'hB1);

    // T4: busy blocks start; then single-cycle latency and data hold
    tx_busy = 1'b1; req = 3'b100; set_byte(2, 8'h5A);
    repeat (3) tick();
    chk("t4_busy_start", 32'(tx_start), 32'd0);
    chk("t4_busy_gnt", 32'(gnt), 32'd0);
    tx_busy = 1'b0;
    tick();
    chk("t4_start", 32'(tx_start), 32'd1);
    chk("t4_gnt", 32'(gnt), 32'b100);
    chk("t4_data", 32'(tx_data), 32'h5A);
    chk("t4_owner", 32'(owner), 32'd2);
    req = 3'b000; set_byte(2, 8'hFF);
    tick();
    chk("t4_start_drop", 32'(tx_start), 32'd0);
    chk("t4_gnt_drop", 32'(gnt), 32'd0);
    chk("t4_data_latched", 32'(tx_data), 32'h5A);
    finish("t4", 8, 8'h5A);

    // T5: watchdog fires 20 cycles after ISSUE, then the next request is served
    req = 3'b010; set_byte(1, 8'h77);
    expect_start("t5", 1, 8'h77, w);
    req = 3'b000;
    repeat (20) tick();
    chk("t5_err_early", 32'(timeout_err), 32'd0);
    tick();
    chk("t5_err_set", 32'(timeout_err), 32'd1);
    req = 3'b001; set_byte(0, 8'h99);
    expect_start("t5_next", 0, 8'h99, w);
    chk("t5_err_sticky", 32'(timeout_err), 32'd1);
    req = 3'b000;
    finish("t5_next", 5, 8'h99);
    chk("t5_err_clear", 32'(timeout_err), 32'd0);

    // T6: reset in WAIT_DONE; pointer restarts at index 0
    req = 3'b001; set_byte(0, 8'hC3);
    expect_start("t6", 0, 8'hC3, w);
    tx_busy = 1'b1;
    tick(); tick();
    req = 3'b011; set_byte(0, 8'hD4); set_byte(1, 8'hE5);
    rst = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_start", 32'(tx_start), 32'd0);
    chk("t6_rst_data", 32'(tx_data), 32'h00);
    chk("t6_rst_owner", 32'(owner), 32'd0);
    chk("t6_rst_err", 32'(timeout_err), 32'd0);
    tx_busy = 1'b0;
    tick();
    rst = 1'b1;
    expect_start("t6_after", 0, 8'hD4, w);
    req = 3'b000;
    finish("t6_after", 5, 8'hD4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
